// File: rtl/simon_pkg.sv
// Shared types and sizes for the SIMON-128/256 host port.
//   N          word width in bits (block = 2*N)
//   M          key words
//   block_t    one cipher block
//   key_t      full key, M words of N bits
//   key_fsm_t  key capture/schedule sequencing states
//   data_fsm_t block capture/round sequencing states
package simon_pkg;
    localparam int N = 64;
    localparam int M = 4;

    typedef logic [2*N-1:0]        block_t;
    typedef logic [M-1:0][N-1:0]   key_t;

    typedef enum logic [1:0] {
        K_IDLE,
        K_ACK,
        K_RUN,
        K_READY
    } key_fsm_t;

    typedef enum logic [2:0] {
        D_IDLE,
        D_ACK,
        D_WAITKEY,
        D_RUN,
        D_DONE,
        D_READ
    } data_fsm_t;
endpackage

// File: rtl/simon_host_port_if.sv
// Host-side bus of the SIMON host port.
//   master : host (drives requests, block, key; receives acks and cipher)
//   slave  : simon_host_port responder
interface simon_host_port_if;
    import simon_pkg::*;

    logic   newData;
    logic   newKey;
    logic   readData;
    logic   enc_dec;
    block_t plain;
    key_t   key;
    logic   ldData;
    logic   ldKey;
    logic   doneData;
    logic   doneKey;
    block_t cipher;

    modport master (
        output newData, newKey, readData, enc_dec, plain, key,
        input  ldData, ldKey, doneData, doneKey, cipher
    );

    modport slave (
        input  newData, newKey, readData, enc_dec, plain, key,
        output ldData, ldKey, doneData, doneKey, cipher
    );
endinterface

// File: rtl/simon_hs4.sv
// Four-phase request/ack register.
//   clk, R  clock, synchronous active-high reset
//   req     request level from the host
//   en      owner is able to accept a request this cycle
//   disarm  a request seen while this is high counts as stale
//   take    combinational capture strobe (req && armed && en)
//   ack     held from capture until req drops
// A request must be seen low after each capture before it can be taken again;
// with disarm high, a request that rises while the owner is busy must also
// drop and rise again.
module simon_hs4 (
    input  logic clk,
    input  logic R,
    input  logic req,
    input  logic en,
    input  logic disarm,
    output logic take,
    output logic ack
);
    logic armed;

    assign take = req && armed && en;

    always_ff @(posedge clk) begin
        if (R) begin
            armed <= 1'b1;
            ack   <= 1'b0;
        end else begin
            if (take)
                armed <= 1'b0;
            else if (!req)
                armed <= 1'b1;
            else if (disarm)
                armed <= 1'b0;

            if (take)
                ack <= 1'b1;
            else if (!req)
                ack <= 1'b0;
        end
    end
endmodule

// File: rtl/simon_host_port.sv
// SIMON-128/256 host port: captures block and key from the host, sequences
// the external key-schedule and round engines, holds the result until read.
//   clk, R                    clock, synchronous active-high reset
//   hif                       host bus (slave side)
//   ks_start/ks_key/ks_done   key-schedule engine control
//   rnd_start/rnd_mode/rnd_blk/rnd_done/rnd_out  round engine control
//
// Key FSM   state     | meaning
//           K_IDLE    | no key loaded
//           K_ACK     | key captured, ldKey high, waiting for newKey low
//           K_RUN     | key schedule running
//           K_READY   | schedule done, doneKey high
// Data FSM  state     | meaning
//           D_IDLE    | waiting for newData
//           D_ACK     | block captured, ldData high, waiting for newData low
//           D_WAITKEY | block waiting for a usable key
//           D_RUN     | round engine running
//           D_DONE    | doneData high, waiting for readData
//           D_READ    | waiting for readData low
module simon_host_port
    import simon_pkg::*;
(
    input  logic   clk,
    input  logic   R,
    simon_host_port_if.slave hif,
    output logic   ks_start,
    output key_t   ks_key,
    input  logic   ks_done,
    output logic   rnd_start,
    output logic   rnd_mode,
    output block_t rnd_blk,
    input  logic   rnd_done,
    input  block_t rnd_out
);
    key_fsm_t  k_state, k_next;
    data_fsm_t d_state, d_next;
    logic      k_take, d_take, k_en, d_en;
    logic      ld_key, ld_data;
    logic      ks_start_nx, rnd_start_nx, cipher_ld;
    logic      done_key, done_data;
    block_t    cipher_q;

    // The key may only change while no block depends on it.
    assign k_en = (k_state == K_IDLE || k_state == K_READY) &&
                  (d_state == D_IDLE || d_state == D_DONE);
    assign d_en = (d_state == D_IDLE);

    simon_hs4 u_hs_key (
        .clk(clk), .R(R), .req(hif.newKey), .en(k_en), .disarm(1'b0),
        .take(k_take), .ack(ld_key)
    );

    // newData raised while busy is stale and needs a fresh low-to-high.
    simon_hs4 u_hs_data (
        .clk(clk), .R(R), .req(hif.newData), .en(d_en), .disarm(!d_en),
        .take(d_take), .ack(ld_data)
    );

    always_comb begin
        k_next      = k_state;
        ks_start_nx = 1'b0;
        case (k_state)
            K_IDLE, K_READY: if (k_take) k_next = K_ACK;
            K_ACK: if (!hif.newKey) begin
                k_next      = K_RUN;
                ks_start_nx = 1'b1;
            end
            K_RUN: if (ks_done) k_next = K_READY;
            default: k_next = K_IDLE;
        endcase
    end

    always_comb begin
        d_next       = d_state;
        rnd_start_nx = 1'b0;
        cipher_ld    = 1'b0;
        case (d_state)
            D_IDLE: if (d_take) d_next = D_ACK;
            D_ACK: if (!hif.newData) begin
                if (done_key) begin
                    d_next       = D_RUN;
                    rnd_start_nx = 1'b1;
                end else begin
                    d_next = D_WAITKEY;
                end
            end
            D_WAITKEY: if (done_key) begin
                d_next       = D_RUN;
                rnd_start_nx = 1'b1;
            end
            D_RUN: if (rnd_done) begin
                d_next    = D_DONE;
                cipher_ld = 1'b1;
            end
            D_DONE: if (hif.readData) d_next = D_READ;
            D_READ: if (!hif.readData) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (R) begin
            k_state   <= K_IDLE;
            d_state   <= D_IDLE;
            ks_start  <= 1'b0;
            rnd_start <= 1'b0;
            done_key  <= 1'b0;
            done_data <= 1'b0;
            ks_key    <= '0;
            rnd_blk   <= '0;
            rnd_mode  <= 1'b0;
            cipher_q  <= '0;
        end else begin
            k_state   <= k_next;
            d_state   <= d_next;
            ks_start  <= ks_start_nx;
            rnd_start <= rnd_start_nx;
            done_key  <= (k_next == K_READY);
            done_data <= (d_next == D_DONE);
            if (k_take)
                ks_key <= hif.key;
            if (d_take) begin
                rnd_blk  <= hif.plain;
                rnd_mode <= hif.enc_dec;
            end
            if (cipher_ld)
                cipher_q <= rnd_out;
        end
    end

    assign hif.ldKey    = ld_key;
    assign hif.ldData   = ld_data;
    assign hif.doneKey  = done_key;
    assign hif.doneData = done_data;
    assign hif.cipher   = cipher_q;
endmodule

// File: tb/tb_simon_host_port.sv
module tb_simon_host_port;
    import simon_pkg::*;

    localparam key_t   KEY  = 256'h1f1e1d1c1b1a1918171615141312111_00f0e0d0c0b0a09080706050403020100;
    localparam key_t   KEY2 = 256'hdeadbeef_01234567_89abcdef_cafef00d_11223344_55667788_99aabbcc_ddeeff00;
    localparam block_t PT   = 128'h74206e69206d6f6f6d69732061207369;
    localparam block_t CT   = 128'h8d2b5579afc8a3a03bf72a87efe7b868;

    logic   clk = 1'b0;
    logic   R;
    logic   ks_start, ks_done, rnd_start, rnd_mode, rnd_done;
    key_t   ks_key;
    block_t rnd_blk, rnd_out;
    int     checks = 0;
    int     errors = 0;

    simon_host_port_if hif();

    simon_host_port dut (
        .clk(clk), .R(R), .hif(hif),
        .ks_start(ks_start), .ks_key(ks_key), .ks_done(ks_done),
        .rnd_start(rnd_start), .rnd_mode(rnd_mode), .rnd_blk(rnd_blk),
        .rnd_done(rnd_done), .rnd_out(rnd_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1;
        tick();
        tick();
        checks++;
        if ({hif.ldData, hif.ldKey, hif.doneData, hif.doneKey, ks_start, rnd_start, rnd_mode} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags act=%b exp=0", {hif.ldData, hif.ldKey, hif.doneData, hif.doneKey, ks_start, rnd_start, rnd_mode});
        end
        checks++;
        if (hif.cipher !== '0 || rnd_blk !== '0 || ks_key !== '0) begin
            errors++;
            $display("FAIL reset_buses cipher=%h blk=%h key=%h exp=0", hif.cipher, rnd_blk, ks_key);
        end
        R = 1'b0;
        tick();
    endtask

    task automatic test_encrypt();
        int starts = 0;
        hif.newKey = 1'b1; hif.newData = 1'b1; hif.key = KEY; hif.plain = PT; hif.enc_dec = 1'b1;
        tick();
        checks++;
        if (hif.ldKey !== 1'b1 || hif.ldData !== 1'b1) begin
            errors++;
            $display("FAIL enc_ack ldKey=%b ldData=%b exp=1 1", hif.ldKey, hif.ldData);
        end
        hif.newKey = 1'b0; hif.newData = 1'b0;
        tick();
        checks++;
        if (ks_start !== 1'b1 || rnd_start !== 1'b0 || hif.ldKey !== 1'b0 || hif.ldData !== 1'b0) begin
            errors++;
            $display("FAIL enc_ks_start ks_start=%b rnd_start=%b ld=%b%b exp=1 0 00", ks_start, rnd_start, hif.ldKey, hif.ldData);
        end
        checks++;
        if (ks_key !== KEY || rnd_blk !== PT || rnd_mode !== 1'b1) begin
            errors++;
            $display("FAIL enc_regs key=%h blk=%h mode=%b", ks_key, rnd_blk, rnd_mode);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rnd_start === 1'b1 || ks_start === 1'b1) starts++;
        end
        checks++;
        if (starts !== 0) begin
            errors++;
            $display("FAIL enc_wait_key stray_starts=%0d exp=0", starts);
        end
        ks_done = 1'b1;
        tick();
        ks_done = 1'b0;
        checks++;
        if (hif.doneKey !== 1'b1 || rnd_start !== 1'b0) begin
            errors++;
            $display("FAIL enc_donekey doneKey=%b rnd_start=%b exp=1 0", hif.doneKey, rnd_start);
        end
        tick();
        checks++;
        if (rnd_start !== 1'b1) begin
            errors++;
            $display("FAIL enc_rnd_start act=%b exp=1", rnd_start);
        end
        tick();
        checks++;
        if (rnd_start !== 1'b0) begin
            errors++;
            $display("FAIL enc_rnd_pulse act=%b exp=0", rnd_start);
        end
        tick();
        rnd_out = CT; rnd_done = 1'b1;
        tick();
        rnd_done = 1'b0; rnd_out = '1;
        checks++;
        if (hif.doneData !== 1'b1 || hif.cipher !== CT) begin
            errors++;
            $display("FAIL enc_result doneData=%b cipher=%h exp=1 %h", hif.doneData, hif.cipher, CT);
        end
        hif.readData = 1'b1;
        tick();
        checks++;
        if (hif.doneData !== 1'b0 || hif.cipher !== CT) begin
            errors++;
            $display("FAIL enc_read doneData=%b cipher=%h exp=0 %h", hif.doneData, hif.cipher, CT);
        end
        hif.readData = 1'b0;
        tick();
    endtask

    task automatic test_decrypt_hold();
        int bad = 0;
        hif.newData = 1'b1; hif.plain = CT; hif.enc_dec = 1'b0;
        tick();
        checks++;
        if (hif.ldData !== 1'b1) begin
            errors++;
            $display("FAIL dec_ack ldData=%b exp=1", hif.ldData);
        end
        hif.newData = 1'b0;
        tick();
        checks++;
        if (rnd_start !== 1'b1 || rnd_mode !== 1'b0 || rnd_blk !== CT) begin
            errors++;
            $display("FAIL dec_start start=%b mode=%b blk=%h exp=1 0 %h", rnd_start, rnd_mode, rnd_blk, CT);
        end
        tick();
        rnd_out = PT; rnd_done = 1'b1;
        tick();
        rnd_done = 1'b0; rnd_out = '0;
        checks++;
        if (hif.doneData !== 1'b1 || hif.cipher !== PT) begin
            errors++;
            $display("FAIL dec_result doneData=%b cipher=%h exp=1 %h", hif.doneData, hif.cipher, PT);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hif.doneData !== 1'b1 || hif.cipher !== PT) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable bad_cycles=%0d exp=0", bad);
        end
        hif.readData = 1'b1;
        tick();
        checks++;
        if (hif.doneData !== 1'b0 || hif.cipher !== PT) begin
            errors++;
            $display("FAIL hold_read doneData=%b cipher=%h exp=0 %h", hif.doneData, hif.cipher, PT);
        end
        hif.readData = 1'b0;
        tick();
    endtask

    task automatic test_key_defer();
        int bad = 0;
        hif.newData = 1'b1; hif.plain = PT; hif.enc_dec = 1'b1;
        tick();
        hif.newData = 1'b0;
        tick();
        hif.newKey = 1'b1; hif.key = KEY2;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (hif.ldKey !== 1'b0 || ks_key !== KEY) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL defer_run bad_cycles=%0d ldKey=%b ks_key=%h", bad, hif.ldKey, ks_key);
        end
        rnd_out = CT; rnd_done = 1'b1;
        tick();
        rnd_done = 1'b0;
        checks++;
        if (hif.doneData !== 1'b1 || hif.ldKey !== 1'b0) begin
            errors++;
            $display("FAIL defer_done doneData=%b ldKey=%b exp=1 0", hif.doneData, hif.ldKey);
        end
        tick();
        checks++;
        if (hif.ldKey !== 1'b1 || hif.doneKey !== 1'b0 || ks_key !== KEY2 || hif.doneData !== 1'b1) begin
            errors++;
            $display("FAIL defer_capture ldKey=%b doneKey=%b ks_key=%h doneData=%b", hif.ldKey, hif.doneKey, ks_key, hif.doneData);
        end
        hif.newKey = 1'b0;
        tick();
        checks++;
        if (ks_start !== 1'b1) begin
            errors++;
            $display("FAIL defer_ks_start act=%b exp=1", ks_start);
        end
        ks_done = 1'b1;
        tick();
        ks_done = 1'b0;
        hif.readData = 1'b1;
        tick();
        hif.readData = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int bad = 0;
        hif.newData = 1'b1; hif.plain = CT; hif.enc_dec = 1'b0;
        tick();
        hif.newData = 1'b0;
        tick();
        tick();
        R = 1'b1; rnd_out = PT; rnd_done = 1'b1;
        tick();
        R = 1'b0;
        checks++;
        if ({hif.ldData, hif.ldKey, hif.doneData, hif.doneKey, ks_start, rnd_start, rnd_mode} !== 7'b0 ||
            hif.cipher !== '0 || rnd_blk !== '0 || ks_key !== '0) begin
            errors++;
            $display("FAIL rst_run flags=%b cipher=%h blk=%h key=%h exp=0",
                     {hif.ldData, hif.ldKey, hif.doneData, hif.doneKey, ks_start, rnd_start, rnd_mode}, hif.cipher, rnd_blk, ks_key);
        end
        tick();
        rnd_done = 1'b0; ks_done = 1'b1;
        tick();
        ks_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (hif.doneData !== 1'b0 || hif.cipher !== '0 || hif.doneKey !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_late_done bad_cycles=%0d doneData=%b doneKey=%b", bad, hif.doneData, hif.doneKey);
        end
    endtask

    task automatic test_newdata_held();
        int bad = 0;
        hif.newKey = 1'b1; hif.key = KEY;
        tick();
        hif.newKey = 1'b0;
        tick();
        ks_done = 1'b1;
        tick();
        ks_done = 1'b0;
        hif.newData = 1'b1; hif.plain = PT; hif.enc_dec = 1'b1;
        tick();
        hif.newData = 1'b0;
        tick();
        hif.newData = 1'b1;
        tick();
        rnd_out = CT; rnd_done = 1'b1;
        tick();
        rnd_done = 1'b0;
        hif.readData = 1'b1;
        tick();
        hif.readData = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (hif.ldData !== 1'b0 || rnd_blk !== PT) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL held_no_recapture bad_cycles=%0d ldData=%b", bad, hif.ldData);
        end
        hif.newData = 1'b0;
        tick();
        hif.newData = 1'b1; hif.plain = CT;
        tick();
        checks++;
        if (hif.ldData !== 1'b1 || rnd_blk !== CT) begin
            errors++;
            $display("FAIL held_recapture ldData=%b blk=%h exp=1 %h", hif.ldData, rnd_blk, CT);
        end
        hif.newData = 1'b0;
        tick();
    endtask

    initial begin
        R = 1'b1;
        hif.newData = 1'b0; hif.newKey = 1'b0; hif.readData = 1'b0; hif.enc_dec = 1'b0;
        hif.plain = '0; hif.key = '0;
        ks_done = 1'b0; rnd_done = 1'b0; rnd_out = '0;
        test_reset();
        test_encrypt();
        test_decrypt_hold();
        test_key_defer();
        test_reset_mid_run();
        test_newdata_held();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_reached checks=%0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/simon_host_port.md
Name: simon_host_port

Overview:
- Responder end of the SIMON-128/256 host handshake. A host drives newData/newKey/readData/enc_dec; this block answers with ldData/ldKey/doneData/doneKey/cipher.
- Captures block and key, sequences an external key-schedule engine and round engine, and holds the result until the host reads it.
- Sits between the host bus and the cipher datapath as the control front-end of the cipher top level.

Parameters:
- N, 64, word width in bits (block = 2*N).
- M, 4, key words.

Ports:
- clk  in  1  clock, all logic on rising edge.
- R  in  1  reset, synchronous, active-high.
- newData  in  1  host request: plain/enc_dec valid.
- newKey  in  1  host request: key valid.
- readData  in  1  host has taken cipher.
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with plain.
- plain  in  2*N  input block.
- key  in  M*N  key, [M-1:0][N-1:0].
- ldData  out  1  data captured ack.
- ldKey  out  1  key captured ack.
- doneData  out  1  cipher valid.
- doneKey  out  1  key schedule complete and usable.
- cipher  out  2*N  result block.
- ks_start  out  1  one-cycle pulse to key-schedule engine.
- ks_key  out  M*N  registered key to engine.
- ks_done  in  1  key-schedule engine finished (one-cycle pulse).
- rnd_start  out  1  one-cycle pulse to round engine.
- rnd_mode  out  1  registered enc_dec.
- rnd_blk  out  2*N  registered block.
- rnd_done  in  1  round engine finished (pulse).
- rnd_out  in  2*N  engine result, valid on the rnd_done cycle.

Behaviour:
- Reset (R high at an edge): all outputs 0, both FSMs idle.
  - Reset mid-operation aborts. Engines share R.
  - A late ks_done/rnd_done after reset is ignored.
- Key FSM states:
  - K_IDLE: on newKey=1 and data FSM in D_IDLE or D_DONE, register key, set ldKey=1, clear doneKey, go to K_ACK.
  - K_ACK: on newKey=0, drop ldKey, pulse ks_start for 1 cycle, go to K_RUN.
  - K_RUN: on ks_done, set doneKey=1, go to K_READY.
  - K_READY: newKey=1 with data FSM idle/done → same action as K_IDLE.
  - newKey while the data FSM is D_WAITKEY/D_RUN is deferred. The key must never change under a running block.
- Data FSM states:
  - D_IDLE: on newData=1, register plain and enc_dec, set ldData=1, go to D_ACK.
  - D_ACK: on newData=0, drop ldData. Go to D_RUN with a 1-cycle rnd_start pulse if doneKey=1, else go to D_WAITKEY.
  - D_WAITKEY: when doneKey=1, pulse rnd_start, go to D_RUN.
  - D_RUN: on rnd_done, register cipher<=rnd_out, set doneData=1, go to D_DONE.
  - D_DONE: on readData=1, drop doneData, go to D_READ. cipher is held.
  - D_READ: on readData=0, go to D_IDLE.
- Four-phase handshakes:
  - ldData/ldKey stay high until the host drops the request.
  - doneData stays high until readData rises.
  - newData held high from a previous cycle is not re-captured until it has been seen low.
- cipher keeps its last value until the next rnd_done. It is not cleared on readData.
- Latency:
  - ldData rises 1 cycle after newData is first seen.
  - rnd_start occurs the cycle after newData is seen low.
  - doneData rises the cycle after rnd_done.
- Simultaneous events:
  - rnd_done and R in the same cycle: R wins.
  - newKey and newData in the same cycle from idle: both are captured. Data waits in D_WAITKEY for ks_done.
- Engine done pulses outside K_RUN/D_RUN are ignored.

Decomposition:
- Package simon_pkg: N/M defaults, key_fsm_t and data_fsm_t enums, block_t = logic [2*N-1:0].
- One sub-module, simon_hs4: generic four-phase request/ack register. Instantiated for the data and key captures.

Test Plan:
- Reset then key=1F1E1D1C…0100 and plain=74206E69206D6F6F6D69732061207369, enc_dec=1, both requests together.
  - Expect ldKey and ldData on the next cycle; data waits for ks_done.
  - rnd_start only after doneKey.
  - With the stub engine returning 8D2B5579AFC8A3A03BF72A87EFE7B868, expect doneData and that exact cipher.
- Feed that cipher back with enc_dec=0 → rnd_mode=0, rnd_blk=8D2B…B868.
  - With stub output 74206E69…7369, expect doneData and matching cipher.
- Hold readData=0 for 20 cycles → doneData and cipher stable throughout.
  - Raise readData → doneData falls next cycle.
- Assert newKey during D_RUN → no ldKey until the block completes and reaches D_DONE.
  - ks_key must be unchanged during the run.
- Assert R during D_RUN, then pulse rnd_done → all outputs 0, doneData never asserts.
- Keep newData high across completion → no second capture until newData has gone low.
